// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stage bits, stall patterns, FSM states.
package stall_ctrl_pkg;

    localparam int unsigned STG_PC  = 0;
    localparam int unsigned STG_IF  = 1;
    localparam int unsigned STG_ID  = 2;
    localparam int unsigned STG_EX  = 3;
    localparam int unsigned STG_MEM = 4;
    localparam int unsigned STG_WB  = 5;
    localparam int unsigned NUM_STG = 6;

    localparam logic [NUM_STG-1:0] STALL_NONE = 6'b000000;
    localparam logic [NUM_STG-1:0] STALL_ID   = 6'b000111;
    localparam logic [NUM_STG-1:0] STALL_EX   = 6'b001111;

    typedef enum logic {
        StIdle,
        StExBusy
    } state_e;

endpackage

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: ID load-use stalls, multi-cycle EX stalls, registered flush
// and a saturating stall-cycle counter.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned EX_MAX_CYC = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id_i,
    input  logic             ex_start_i,
    input  logic [5:0]       ex_cycles_i,
    input  logic             flush_i,
    input  logic             cnt_clr_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic             ex_busy_o,
    output logic             ex_done_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [5:0] EX_MAX = 6'(EX_MAX_CYC);

    state_e           state_q, state_d;
    logic [5:0]       rem_q, rem_d;
    logic             flush_q;
    logic [CNT_W-1:0] cnt_q;

    logic [5:0] n_eff;
    logic [5:0] stall_raw;
    logic       busy_raw;
    logic       done_raw;

    assign n_eff = (ex_cycles_i > EX_MAX) ? EX_MAX : ex_cycles_i;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        stall_raw = STALL_NONE;
        busy_raw  = 1'b0;
        done_raw  = 1'b0;
        if (flush_i) begin
            state_d = StIdle;
            rem_d   = 6'd0;
        end else if (state_q == StExBusy) begin
            stall_raw = STALL_EX;
            busy_raw  = 1'b1;
            rem_d     = rem_q - 6'd1;
            if (rem_q <= 6'd1) begin
                done_raw = 1'b1;
                state_d  = StIdle;
                rem_d    = 6'd0;
            end
        end else if (ex_start_i && (n_eff != 6'd0)) begin
            stall_raw = STALL_EX;
            if (n_eff == 6'd1) begin
                done_raw = 1'b1;
            end else begin
                busy_raw = 1'b1;
                state_d  = StExBusy;
                rem_d    = n_eff - 6'd1;
            end
        end else if (stallreq_id_i) begin
            stall_raw = STALL_ID;
        end
    end

    // Combinational outputs are forced quiet while reset is held, whatever the inputs do.
    assign stall_o     = rst ? stall_raw : STALL_NONE;
    assign ex_busy_o   = rst & busy_raw;
    assign ex_done_o   = rst & done_raw;
    assign flush_o     = flush_q;
    assign stall_cnt_o = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            rem_q   <= 6'd0;
            flush_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            flush_q <= flush_i;
            if (cnt_clr_i) begin
                cnt_q <= '0;
            end else if ((stall_raw != STALL_NONE) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl: vector table plus hand-written multi-cycle cases.
module tb_stall_ctrl;

    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic          stallreq_id_i;
    logic          ex_start_i;
    logic [5:0]    ex_cycles_i;
    logic          flush_i;
    logic          cnt_clr_i;
    logic [5:0]    stall_o;
    logic          flush_o;
    logic          ex_busy_o;
    logic          ex_done_o;
    logic [CW-1:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    stall_ctrl #(
        .EX_MAX_CYC (32),
        .CNT_W      (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_id_i (stallreq_id_i),
        .ex_start_i    (ex_start_i),
        .ex_cycles_i   (ex_cycles_i),
        .flush_i       (flush_i),
        .cnt_clr_i     (cnt_clr_i),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .ex_busy_o     (ex_busy_o),
        .ex_done_o     (ex_done_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sr;
        logic       st;
        logic [5:0] n;
        logic       fl;
        logic       clr;
        logic [5:0] e_stall;
        logic       e_busy;
        logic       e_done;
        logic       e_fo;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sr, input logic st, input logic [5:0] n,
                         input logic fl, input logic clr);
        stallreq_id_i = sr;
        ex_start_i    = st;
        ex_cycles_i   = n;
        flush_i       = fl;
        cnt_clr_i     = clr;
    endtask

    task automatic set_vec(input int i, input logic sr, input logic st, input logic [5:0] n,
                           input logic fl, input logic clr, input logic [5:0] es,
                           input logic eb, input logic ed, input logic ef, input logic [3:0] ec);
        vecs[i] = '{sr, st, n, fl, clr, es, eb, ed, ef, ec};
    endtask

    initial begin
        int ex_cyc;
        int done_at;
        bit stop;

        //          sr st n   fl clr  stall      busy done fo cnt
        set_vec( 0, 0, 0, 0,  0, 0,   6'h00,     0,   0,   0, 0);
        set_vec( 1, 0, 1, 5,  0, 0,   6'h0F,     1,   0,   0, 0);
        set_vec( 2, 0, 0, 0,  0, 0,   6'h0F,     1,   0,   0, 1);
        set_vec( 3, 0, 1, 3,  0, 0,   6'h0F,     1,   0,   0, 2);
        set_vec( 4, 0, 0, 0,  0, 0,   6'h0F,     1,   0,   0, 3);
        set_vec( 5, 0, 0, 0,  0, 0,   6'h0F,     1,   1,   0, 4);
        set_vec( 6, 0, 0, 0,  0, 1,   6'h00,     0,   0,   0, 5);
        set_vec( 7, 0, 1, 1,  0, 0,   6'h0F,     0,   1,   0, 0);
        set_vec( 8, 0, 1, 0,  0, 0,   6'h00,     0,   0,   0, 1);
        set_vec( 9, 1, 0, 0,  0, 0,   6'h07,     0,   0,   0, 1);
        set_vec(10, 1, 1, 4,  0, 0,   6'h0F,     1,   0,   0, 2);
        set_vec(11, 1, 0, 0,  0, 0,   6'h0F,     1,   0,   0, 3);
        set_vec(12, 1, 0, 0,  0, 0,   6'h0F,     1,   0,   0, 4);
        set_vec(13, 1, 0, 0,  0, 0,   6'h0F,     1,   1,   0, 5);
        set_vec(14, 1, 0, 0,  0, 0,   6'h07,     0,   0,   0, 6);
        set_vec(15, 0, 0, 0,  0, 1,   6'h00,     0,   0,   0, 7);
        set_vec(16, 0, 1, 8,  0, 0,   6'h0F,     1,   0,   0, 0);
        set_vec(17, 0, 0, 0,  0, 0,   6'h0F,     1,   0,   0, 1);
        set_vec(18, 0, 0, 0,  1, 0,   6'h00,     0,   0,   0, 2);
        set_vec(19, 0, 0, 0,  0, 0,   6'h00,     0,   0,   1, 2);
        set_vec(20, 0, 0, 0,  0, 0,   6'h00,     0,   0,   0, 2);
        set_vec(21, 1, 1, 5,  1, 0,   6'h00,     0,   0,   0, 2);
        set_vec(22, 0, 0, 0,  0, 0,   6'h00,     0,   0,   1, 2);
        set_vec(23, 1, 0, 0,  0, 0,   6'h07,     0,   0,   0, 2);

        // Reset held with active requests: everything quiet.
        rst = 1'b0;
        drive(1, 1, 6'd5, 1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_busy", 32'(ex_busy_o), 32'h0);
        chk("rst_done", 32'(ex_done_o), 32'h0);
        chk("rst_flush_o", 32'(flush_o), 32'h0);
        chk("rst_cnt", 32'(stall_cnt_o), 32'h0);
        drive(0, 0, 6'd0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].sr, vecs[i].st, vecs[i].n, vecs[i].fl, vecs[i].clr);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), 32'(stall_o), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_busy", i), 32'(ex_busy_o), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d_done", i), 32'(ex_done_o), 32'(vecs[i].e_done));
            chk($sformatf("v%0d_flush_o", i), 32'(flush_o), 32'(vecs[i].e_fo));
            chk($sformatf("v%0d_cnt", i), 32'(stall_cnt_o), 32'(vecs[i].e_cnt));
            @(posedge clk);
            #1;
        end

        // N=40 clamps to 32 stall cycles with done in the last one.
        drive(0, 1, 6'd40, 0, 0);
        ex_cyc  = 0;
        done_at = 0;
        stop    = 1'b0;
        for (int c = 0; c < 80 && !stop; c++) begin
            @(negedge clk);
            if (stall_o == 6'h0F) begin
                ex_cyc++;
                if (ex_done_o) done_at = ex_cyc;
            end else begin
                stop = 1'b1;
            end
            @(posedge clk);
            #1;
            ex_start_i = 1'b0;
        end
        chk("clamp_cycles", 32'(ex_cyc), 32'd32);
        chk("clamp_done_at", 32'(done_at), 32'd32);
        chk("clamp_cnt_sat", 32'(stall_cnt_o), 32'hF);

        // Saturation: clear, 14 ID stalls reach 2^CW-2, three more pin at all-ones.
        drive(0, 0, 6'd0, 0, 1);
        @(posedge clk);
        #1;
        drive(1, 0, 6'd0, 0, 0);
        repeat (14) @(posedge clk);
        #1;
        chk("cnt_preload", 32'(stall_cnt_o), 32'hE);
        repeat (3) @(posedge clk);
        #1;
        chk("cnt_saturate", 32'(stall_cnt_o), 32'hF);
        cnt_clr_i = 1'b1;
        @(negedge clk);
        chk("clr_with_stall", 32'(stall_o), 32'h07);
        @(posedge clk);
        #1;
        chk("cnt_clear_wins", 32'(stall_cnt_o), 32'h0);

        // Asynchronous reset in the middle of an EX op.
        drive(0, 1, 6'd8, 0, 0);
        @(posedge clk);
        #1;
        ex_start_i = 1'b0;
        @(posedge clk);
        #2;
        chk("mid_busy_before", 32'(ex_busy_o), 32'h1);
        rst = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall_o), 32'h0);
        chk("mid_rst_busy", 32'(ex_busy_o), 32'h0);
        chk("mid_rst_cnt", 32'(stall_cnt_o), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_rst_stall", 32'(stall_o), 32'h0);
        chk("post_rst_busy", 32'(ex_busy_o), 32'h0);
        chk("post_rst_done", 32'(ex_done_o), 32'h0);
        ex_start_i  = 1'b1;
        ex_cycles_i = 6'd2;
        #1;
        chk("post_rst_start", 32'(stall_o), 32'h0F);
        chk("post_rst_start_busy", 32'(ex_busy_o), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
